// File: rtl/coprime_pkg.sv
// coprime_pkg -- shared types and constants for the coprime_gcd block.
//   state_t        : FSM states of the binary GCD engine (IDLE, STRIP, REDUCE)
//   DEFAULT_WIDTH  : default operand width
//   k_width(w)     : width of the common power-of-two shift counter k
package coprime_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIP  = 2'd1,
    REDUCE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // k counts shared trailing zeros; it can reach WIDTH-1, so
  // clog2(WIDTH)+1 bits always holds it.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/coprime_gcd_step.sv
// coprime_gcd_step -- one combinational step of the binary (Stein) GCD.
// Ports:
//   state, u, v, k                      : current engine state and registers
//   state_nxt, u_nxt, v_nxt, k_nxt      : values for the next clock
//   finish                              : result is ready this step
//   result                              : gcd value when finish=1
module coprime_gcd_step
  import coprime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int KW    = k_width(WIDTH)
) (
  input  state_t           state,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [KW-1:0]    k,
  output state_t           state_nxt,
  output logic [WIDTH-1:0] u_nxt,
  output logic [WIDTH-1:0] v_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             finish,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    state_nxt = state;
    u_nxt     = u;
    v_nxt     = v;
    k_nxt     = k;
    finish    = 1'b0;
    result    = u << k;
    if (state != IDLE) begin
      // A zero operand only reaches here when a buffered request is
      // launched straight into STRIP; nonzero operands never become zero.
      if (u == '0 || v == '0) begin
        finish = 1'b1;
        result = (u | v) << k;
      end else if (state == STRIP) begin
        if (!u[0] && !v[0]) begin
          u_nxt = u >> 1;
          v_nxt = v >> 1;
          k_nxt = k + KW'(1);
        end else begin
          state_nxt = REDUCE;
        end
      end else begin
        if (!u[0])      u_nxt = u >> 1;
        else if (!v[0]) v_nxt = v >> 1;
        else if (u == v) finish = 1'b1;
        else if (u > v) u_nxt = (u - v) >> 1;
        else            v_nxt = (v - u) >> 1;
      end
      if (finish) state_nxt = IDLE;
    end
  end

endmodule

// File: rtl/coprime_gcd.sv
// coprime_gcd -- sequential coprimality checker (binary GCD, one step/clock).
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start, a, b       : request strobe and operands, taken when ready=1
//   ready             : a start will be accepted
//   busy              : computation in progress
//   done              : one-cycle pulse, gcd/is_coprime valid
//   gcd, is_coprime   : registered result, held until next done
// Build option: COPRIME_REQ_BUF_EN adds a one-entry request buffer so a
// start may be queued while busy; ready then reflects buffer occupancy.
module coprime_gcd
  import coprime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd,
  output logic             is_coprime
);

  localparam int KW = k_width(WIDTH);

  state_t           state, state_d, s_state;
  logic [WIDTH-1:0] u, v, u_d, v_d, s_u, s_v, s_result, gcd_d;
  logic [KW-1:0]    k, k_d, s_k;
  logic             busy_d, done_d, cop_d, s_finish, accept;

  coprime_gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .state     (state),
    .u         (u),
    .v         (v),
    .k         (k),
    .state_nxt (s_state),
    .u_nxt     (s_u),
    .v_nxt     (s_v),
    .k_nxt     (s_k),
    .finish    (s_finish),
    .result    (s_result)
  );

`ifdef COPRIME_REQ_BUF_EN
  logic             pend_vld, pend_vld_d;
  logic [WIDTH-1:0] pend_a, pend_b, pend_a_d, pend_b_d;
  assign ready = !pend_vld;
`else
  assign ready = !busy;
`endif

  assign accept = start && ready;

  always_comb begin
    state_d = state;
    u_d     = u;
    v_d     = v;
    k_d     = k;
    busy_d  = busy;
    done_d  = 1'b0;
    gcd_d   = gcd;
    cop_d   = is_coprime;
`ifdef COPRIME_REQ_BUF_EN
    pend_vld_d = pend_vld;
    pend_a_d   = pend_a;
    pend_b_d   = pend_b;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          u_d = a;
          v_d = b;
          k_d = '0;
          if (a == '0 || b == '0) begin
            // zero operand: finish on the accepting edge
            done_d = 1'b1;
            gcd_d  = a | b;
            cop_d  = ((a | b) == WIDTH'(1));
          end else begin
            state_d = STRIP;
            busy_d  = 1'b1;
          end
        end
      end
      default: begin
        u_d     = s_u;
        v_d     = s_v;
        k_d     = s_k;
        state_d = s_state;
        if (s_finish) begin
          done_d  = 1'b1;
          gcd_d   = s_result;
          cop_d   = (s_result == WIDTH'(1));
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef COPRIME_REQ_BUF_EN
          // chain the next request on the done edge, no idle cycle
          if (pend_vld) begin
            u_d        = pend_a;
            v_d        = pend_b;
            k_d        = '0;
            state_d    = STRIP;
            busy_d     = 1'b1;
            pend_vld_d = accept;
            pend_a_d   = a;
            pend_b_d   = b;
          end else if (accept) begin
            u_d     = a;
            v_d     = b;
            k_d     = '0;
            state_d = STRIP;
            busy_d  = 1'b1;
          end
`endif
        end
`ifdef COPRIME_REQ_BUF_EN
        else if (accept) begin
          pend_vld_d = 1'b1;
          pend_a_d   = a;
          pend_b_d   = b;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      u          <= '0;
      v          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gcd        <= '0;
      is_coprime <= 1'b0;
`ifdef COPRIME_REQ_BUF_EN
      pend_vld   <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
`endif
    end else begin
      state      <= state_d;
      u          <= u_d;
      v          <= v_d;
      k          <= k_d;
      busy       <= busy_d;
      done       <= done_d;
      gcd        <= gcd_d;
      is_coprime <= cop_d;
`ifdef COPRIME_REQ_BUF_EN
      pend_vld   <= pend_vld_d;
      pend_a     <= pend_a_d;
      pend_b     <= pend_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_coprime_gcd.sv
// tb_coprime_gcd -- self-checking bench for coprime_gcd at WIDTH 4, 8, 16.
// Expected results are queued per instance when a request is accepted and
// compared when that instance pulses done.
module tb_coprime_gcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  st = '0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  rd, by, dn, cp;
  logic [3:0]  g4;
  logic [7:0]  g8;
  logic [15:0] g16;

  int checks = 0, failures = 0, cyc = 0;
  int acc [3];
  logic [15:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coprime_gcd #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(a[3:0]), .b(b[3:0]),
    .ready(rd[0]), .busy(by[0]), .done(dn[0]), .gcd(g4), .is_coprime(cp[0]));
  coprime_gcd #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a[7:0]), .b(b[7:0]),
    .ready(rd[1]), .busy(by[1]), .done(dn[1]), .gcd(g8), .is_coprime(cp[1]));
  coprime_gcd #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(a), .b(b),
    .ready(rd[2]), .busy(by[2]), .done(dn[2]), .gcd(g16), .is_coprime(cp[2]));

  function automatic logic [15:0] gcd_model(input logic [15:0] x, input logic [15:0] y);
    int p = x, q = y, t;
    while (q != 0) begin t = p % q; p = q; q = t; end
    return 16'(p);
  endfunction

  function automatic logic [15:0] obs_gcd(input int i);
    return (i == 0) ? {12'd0, g4} : (i == 1) ? {8'd0, g8} : g16;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin : mon
          logic [15:0] exp, got;
          int sz;
          sz  = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
          got = obs_gcd(i);
          checks++;
          if (sz == 0) begin
            failures++;
            $display("FAIL unexpected_done inst=%0d got gcd=%0d, no request outstanding", i, got);
          end else begin
            case (i)
              0: exp = q0.pop_front();
              1: exp = q1.pop_front();
              default: exp = q2.pop_front();
            endcase
            if (got !== exp) begin
              failures++;
              $display("FAIL gcd inst=%0d got=%0d exp=%0d", i, got, exp);
            end
            checks++;
            if (cp[i] !== (exp == 16'd1)) begin
              failures++;
              $display("FAIL is_coprime inst=%0d got=%0b exp=%0b", i, cp[i], (exp == 16'd1));
            end
`ifndef COPRIME_REQ_BUF_EN
            checks++;
            if (by[i] !== 1'b0) begin
              failures++;
              $display("FAIL busy_with_done inst=%0d got busy=%0b exp=0", i, by[i]);
            end
`endif
          end
        end
      end
    end
  end

  task automatic push_exp(input int sel, input logic [15:0] e);
    case (sel)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // called at a negedge; returns 1ns after the accepting edge
  task automatic issue(input int sel, input logic [15:0] av, input logic [15:0] bv);
    int n = 0;
    while (!rd[sel] && n < 100) begin @(negedge clk); n++; end
    if (!rd[sel]) begin
      checks++; failures++;
      $display("FAIL ready_timeout inst=%0d got ready=0 exp=1", sel);
    end else push_exp(sel, gcd_model(av, bv));
    a = av; b = bv; st[sel] = 1'b1;
    @(posedge clk); #1;
    acc[sel] = cyc;
    st[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (dn[sel]) begin lat = cyc - acc[sel]; return; end
    end
    checks++; failures++;
    $display("FAIL done_timeout inst=%0d got no done within %0d cycles", sel, budget);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dn[i], by[i], cp[i], rd[i]} !== 4'b0001 || obs_gcd(i) !== 16'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got done/busy/cop/ready=%b gcd=%0d exp 0001 gcd=0",
                 i, {dn[i], by[i], cp[i], rd[i]}, obs_gcd(i));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep4;
    int lat;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        issue(0, 16'(x), 16'(y));
        wait_done(0, 2*4+4, lat);
        if (x == 4 && y == 3) begin
          checks++;
          if (lat != 5) begin failures++; $display("FAIL lat_4_3 got=%0d exp=5", lat); end
        end
        if (x == 0 && y == 3) begin
          checks++;
          if (lat != 0) begin failures++; $display("FAIL lat_0_3 got=%0d exp=0", lat); end
        end
        if (x != 0 && y != 0 && lat > 2*4+2) begin
          checks++; failures++;
          $display("FAIL lat_bound4 a=%0d b=%0d got=%0d exp<=10", x, y, lat);
        end
      end
    end
  endtask

  task automatic test_w8;
    int lat;
    issue(1, 16'd0, 16'd0);
    wait_done(1, 20, lat);
    checks++;
    if (lat != 0) begin failures++; $display("FAIL lat_0_0 got=%0d exp=0", lat); end
    issue(1, 16'd48, 16'd180);
    wait_done(1, 20, lat);
    checks++;
    if (lat < 0 || lat > 18) begin failures++; $display("FAIL lat_48_180 got=%0d exp<=18", lat); end
  endtask

  task automatic test_w16;
    int lat;
    issue(2, 16'hFFFF, 16'hFFFE);
    wait_done(2, 40, lat);
    checks++;
    if (lat < 0 || lat > 34) begin failures++; $display("FAIL lat_ffff got=%0d exp<=34", lat); end
    issue(2, 16'h8000, 16'h8000);
    wait_done(2, 40, lat);
  endtask

  task automatic test_busy_start;
    int lat, extra;
    issue(1, 16'd15, 16'd10);
    repeat (2) @(negedge clk);
    checks++;
`ifdef COPRIME_REQ_BUF_EN
    if (rd[1] !== 1'b1) begin failures++; $display("FAIL ready_while_busy got=%b exp=1", rd[1]); end
    push_exp(1, gcd_model(16'd9, 16'd6));
`else
    if (rd[1] !== 1'b0) begin failures++; $display("FAIL ready_while_busy got=%b exp=0", rd[1]); end
`endif
    a = 16'd9; b = 16'd6; st[1] = 1'b1;
    @(posedge clk); #1;
    st[1] = 1'b0;
    wait_done(1, 24, lat);
`ifdef COPRIME_REQ_BUF_EN
    checks++;
    if (by[1] !== 1'b1) begin failures++; $display("FAIL busy_chain got=%b exp=1", by[1]); end
    acc[1] = cyc;
    wait_done(1, 24, lat);
`else
    extra = 0;
    repeat (30) begin @(negedge clk); if (dn[1]) extra++; end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL dropped_start got %0d extra done exp 0", extra); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(1, 16'd48, 16'd180);
    wait_done(1, 24, lat);
    issue(1, 16'd21, 16'd14);
    @(negedge clk);
    checks++;
    if (dn[1] !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", dn[1]); end
    wait_done(1, 24, lat);
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(2, 16'hFFFF, 16'hFFFE);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dn[2], by[2], cp[2], rd[2]} !== 4'b0001 || g16 !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid got done/busy/cop/ready=%b gcd=%0d exp 0001 gcd=0",
               {dn[2], by[2], cp[2], rd[2]}, g16);
    end
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2, 16'd10, 16'd4);
    wait_done(2, 40, lat);
  endtask

  initial begin
    test_reset;
    test_sweep4;
    test_w8;
    test_w16;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    repeat (5) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL outstanding got=%0d results pending exp=0", q0.size() + q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
